// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one instruction-memory request at a time and buffers
// the returned {pc, instruction} pairs in a DEPTH-entry FIFO that decode drains.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [31:0]                pc_i,
  input  logic                       flush_i,
  output logic                       pc_adv_o,
  output logic                       imem_req_o,
  output logic [31:0]                imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [31:0]                imem_data_i,
  input  logic                       deq_i,
  output logic                       valid_o,
  output logic [31:0]                inst_o,
  output logic [31:0]                inst_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t        state_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  logic push;
  logic pop;
  logic issue;

  // A returned word is kept only when the request is still wanted and no redirect lands now.
  assign pc_adv_o = (state_q == S_REQ) && imem_ack_i && !flush_i;
  assign push     = pc_adv_o;
  assign pop      = deq_i && valid_o && !flush_i;
  assign issue    = start_i && !flush_i && (count_q < FULL);

  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;
  assign inst_o    = valid_o ? mem_inst[rd_ptr_q] : '0;
  assign inst_pc_o = valid_o ? mem_pc[rd_ptr_q]   : '0;

  // Request FSM; memory cannot cancel, so a flushed request lingers in DROP until its ack.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_i;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_ack_i) begin
            imem_req_o <= 1'b0;
            state_q    <= S_IDLE;
          end else if (flush_i) begin
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_ack_i) begin
            imem_req_o <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          imem_req_o <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over a same-cycle push or pop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the head outputs are masked by valid_o so stale words never show.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_inst[wr_ptr_q] <= imem_data_i;
      mem_pc[wr_ptr_q]   <= imem_addr_o;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a reference FSM plus an {pc, inst} scoreboard checked every
// cycle, with directed checks for streaming, full queue, wait states, flush and reset.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] XORK = 32'hA5A5_A5A5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        pc_adv_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        deq_i;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [2:0]  count_o;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .pc_i        (pc_i),
    .flush_i     (flush_i),
    .pc_adv_o    (pc_adv_o),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .deq_i       (deq_i),
    .valid_o     (valid_o),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Pending stimulus, applied to the ports at the start of the next cycle.
  logic        t_start = 1'b0, t_deq = 1'b0, t_flush = 1'b0, t_ack = 1'b0, t_redir = 1'b0;
  logic [31:0] t_data = '0, t_redir_pc = '0;

  // Memory model: acks after mem_wait idle REQ cycles with data = addr ^ XORK.
  bit mem_auto = 1'b1;
  int mem_wait = 0;
  int wcnt     = 0;

  // Reference model and scoreboard.
  int          ref_st = 0;  // 0 idle, 1 req, 2 drop
  logic [31:0] ref_addr = '0;
  logic [31:0] pc_next  = '0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] pop_log[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          adv_cnt = 0;
  int          req_cnt;
  int          iss;
  logic        prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_step();
    int          n;
    logic        exp_adv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    if (!rst_i) begin
      ref_st = 0;
      ref_addr = '0;
      exp_pc_q.delete();
      exp_inst_q.delete();
      pc_next = '0;
    end
    n = exp_pc_q.size();
    chk("count", {29'd0, count_o}, n);
    chk("valid", {31'd0, valid_o}, {31'd0, n != 0});
    chk("req", {31'd0, imem_req_o}, {31'd0, ref_st != 0});
    if (ref_st != 0) chk("addr", imem_addr_o, ref_addr);
    exp_adv = rst_i && (ref_st == 1) && imem_ack_i && !flush_i;
    chk("pc_adv", {31'd0, pc_adv_o}, {31'd0, exp_adv});
    if (pc_adv_o) adv_cnt++;
    if (!rst_i) return;
    pc_next = t_redir ? t_redir_pc : (exp_adv ? pc_i + 32'd4 : pc_i);
    if (flush_i) begin
      exp_pc_q.delete();
      exp_inst_q.delete();
    end else begin
      if (deq_i && n > 0) begin
        e_pc   = exp_pc_q.pop_front();
        e_inst = exp_inst_q.pop_front();
        chk("head_pc", inst_pc_o, e_pc);
        chk("head_inst", inst_o, e_inst);
        pop_log.push_back(inst_pc_o);
        pop_cyc.push_back(cyc);
      end
      if (exp_adv) begin
        exp_pc_q.push_back(ref_addr);
        exp_inst_q.push_back(imem_data_i);
      end
    end
    case (ref_st)
      0: if (start_i && !flush_i && n < DEPTH) begin ref_st = 1; ref_addr = pc_i; end
      1: if (imem_ack_i) ref_st = 0; else if (flush_i) ref_st = 2;
      2: if (imem_ack_i) ref_st = 0;
      default: ref_st = 0;
    endcase
  endtask

  // One clock cycle: drive at the falling edge, check just after.
  task automatic step();
    @(negedge clk_i);
    cyc++;
    pc_i    = pc_next;
    start_i = t_start;
    deq_i   = t_deq;
    flush_i = t_flush;
    if (mem_auto) begin
      if (imem_req_o) begin
        if (wcnt >= mem_wait) begin
          imem_ack_i  = 1'b1;
          imem_data_i = imem_addr_o ^ XORK;
          wcnt = 0;
        end else begin
          imem_ack_i = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack_i = 1'b0;
        wcnt = 0;
      end
    end else begin
      imem_ack_i  = t_ack;
      imem_data_i = t_data;
    end
    #1;
    sb_step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b0; start_i = 1'b0; pc_i = '0; flush_i = 1'b0;
    imem_ack_i = 1'b0; imem_data_i = '0; deq_i = 1'b0;

    // Reset state
    step();
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_inst_pc", inst_pc_o, 32'h0);
    step();
    rst_i = 1'b1;

    // Streaming with zero-wait memory and decode always consuming
    adv_cnt = 0;
    pop_log.delete();
    pop_cyc.delete();
    t_start = 1'b1; t_deq = 1'b1; mem_wait = 0;
    repeat (20) step();
    chk("stream_adv_count", adv_cnt, 10);
    chk("stream_pops", pop_log.size(), 9);
    for (int i = 0; i < pop_log.size(); i++) begin
      chk("stream_pc", pop_log[i], 32'(4 * i));
      if (i > 0) chk("stream_spacing", pop_cyc[i] - pop_cyc[i-1], 2);
    end
    t_start = 1'b0;
    repeat (3) step();
    t_flush = 1'b1; t_redir = 1'b1; t_redir_pc = 32'h0;
    step();
    t_flush = 1'b0; t_redir = 1'b0;

    // Fill to DEPTH with no dequeue, then single refill after one pop
    pop_log.delete();
    t_start = 1'b1; t_deq = 1'b0;
    repeat (12) step();
    chk("full_count", {29'd0, count_o}, 4);
    req_cnt = 0;
    repeat (4) begin
      step();
      if (imem_req_o) req_cnt++;
    end
    chk("no_req_when_full", req_cnt, 0);
    t_deq = 1'b1;
    step();
    t_deq = 1'b0;
    iss = 0;
    prev = imem_req_o;
    repeat (6) begin
      step();
      if (imem_req_o && !prev) iss++;
      prev = imem_req_o;
    end
    chk("one_refill", iss, 1);
    chk("refill_count", {29'd0, count_o}, 4);
    t_start = 1'b0; t_deq = 1'b1;
    repeat (5) step();
    chk("fill_pops", pop_log.size(), 5);
    for (int i = 0; i < 4; i++) chk("fill_order", pop_log[i], 32'(4 * i));

    // Request held through three wait cycles
    t_deq = 1'b0;
    t_flush = 1'b1; t_redir = 1'b1; t_redir_pc = 32'h40;
    step();
    t_flush = 1'b0; t_redir = 1'b0;
    mem_wait = 3; t_start = 1'b1; t_deq = 1'b1;
    step();
    t_start = 1'b0;
    repeat (3) begin
      step();
      chk("wait_req", {31'd0, imem_req_o}, 32'd1);
      chk("wait_addr", imem_addr_o, 32'h40);
    end
    step();
    chk("wait_adv", {31'd0, pc_adv_o}, 32'd1);
    step();
    chk("wait_valid", {31'd0, valid_o}, 32'd1);
    chk("wait_head_pc", inst_pc_o, 32'h40);
    chk("wait_head_inst", inst_o, 32'h40 ^ XORK);
    mem_wait = 0;

    // Flush in second REQ cycle, late ack in DROP, redirect to 0x100
    t_deq = 1'b0;
    mem_auto = 1'b0; t_ack = 1'b0;
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    step();
    t_flush = 1'b1; t_redir = 1'b1; t_redir_pc = 32'h100;
    step();
    t_flush = 1'b0; t_redir = 1'b0; t_start = 1'b1;
    step();
    chk("drop_req_held", {31'd0, imem_req_o}, 32'd1);
    chk("drop_addr_held", imem_addr_o, 32'h44);
    t_ack = 1'b1; t_data = 32'hDEAD_BEEF;
    step();
    chk("drop_no_adv", {31'd0, pc_adv_o}, 32'd0);
    t_ack = 1'b0;
    step();
    chk("drop_not_enqueued", {29'd0, count_o}, 0);
    step();
    chk("redirect_addr", imem_addr_o, 32'h100);
    t_start = 1'b0; t_ack = 1'b1; t_data = 32'h100 ^ XORK;
    step();
    t_ack = 1'b0; t_deq = 1'b1;
    step();
    chk("redirect_head_pc", inst_pc_o, 32'h100);
    mem_auto = 1'b1;

    // Flush coincident with ack and dequeue while two entries are held
    t_deq = 1'b0; t_start = 1'b1;
    repeat (5) step();
    t_flush = 1'b1; t_deq = 1'b1; t_start = 1'b0; t_redir = 1'b1; t_redir_pc = 32'h200;
    step();
    chk("coinc_count_before", {29'd0, count_o}, 2);
    chk("coinc_no_adv", {31'd0, pc_adv_o}, 32'd0);
    t_flush = 1'b0; t_deq = 1'b0; t_redir = 1'b0;
    step();
    chk("coinc_count_after", {29'd0, count_o}, 0);
    chk("coinc_valid_after", {31'd0, valid_o}, 32'd0);
    step();
    chk("coinc_still_empty", {29'd0, count_o}, 0);

    // Asynchronous reset during REQ, ack after release
    mem_auto = 1'b0; t_ack = 1'b0; t_start = 1'b1;
    step();
    t_start = 1'b0;
    step();
    chk("pre_rst_req", {31'd0, imem_req_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    pc_i = '0;
    #1;
    chk("async_rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("async_rst_addr", imem_addr_o, 32'h0);
    chk("async_rst_count", {29'd0, count_o}, 0);
    chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("async_rst_inst", inst_o, 32'h0);
    chk("async_rst_inst_pc", inst_pc_o, 32'h0);
    chk("async_rst_adv", {31'd0, pc_adv_o}, 32'd0);
    step();
    rst_i = 1'b1;
    t_ack = 1'b1; t_data = 32'h1234_5678;
    step();
    chk("late_ack_no_adv", {31'd0, pc_adv_o}, 32'd0);
    t_ack = 1'b0;
    step();
    chk("late_ack_count", {29'd0, count_o}, 0);
    chk("late_ack_valid", {31'd0, valid_o}, 32'd0);
    chk("late_ack_req", {31'd0, imem_req_o}, 32'd0);
    mem_auto = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
